card_dealer: RTL and testbench

- Upstream stage of the per-card 7-segment decoders.
- Holds the six card registers for a baccarat round: player cards 1-3 and dealer cards 1-3.
- On each accepted deal request, captures a card value (1..13) into the addressed slot. The value comes from a free-running counter, or from a forced value in test mode.
- Each card output drives one decoder directly. An empty slot reads 0, which the decoder shows as blank.

---
 rtl/card_dealer_pkg.sv | 30 +++
 rtl/card_counter.sv | 23 ++
 rtl/card_dealer.sv | 112 +++++++++++
 tb/tb_card_dealer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_dealer_pkg.sv
// Shared types and constants for the baccarat card path.
// Used by the dealer, the 7-segment decoders and the scoring block.
package card_dealer_pkg;

  localparam int CARD_W    = 4;
  localparam int NUM_SLOTS = 6;
  localparam int SLOT_W    = 3;

  typedef logic [CARD_W-1:0] card_t;
  typedef logic [SLOT_W-1:0] slot_t;

  localparam card_t EMPTY = 4'd0;
  localparam card_t ACE   = 4'd1;
  localparam card_t KING  = 4'd13;

  localparam slot_t SLOT_P1 = 3'd0;
  localparam slot_t SLOT_P2 = 3'd1;
  localparam slot_t SLOT_P3 = 3'd2;
  localparam slot_t SLOT_D1 = 3'd3;
  localparam slot_t SLOT_D2 = 3'd4;
  localparam slot_t SLOT_D3 = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/card_counter.sv
// Free-running card value source, CARD_MIN..CARD_MAX then wrap.
// Advances every cycle out of reset, independent of the dealer FSM.
module card_counter
  import card_dealer_pkg::*;
#(
  parameter int CARD_MIN = 1,
  parameter int CARD_MAX = 13
) (
  input  logic              clk,
  input  logic              reset,
  output logic [CARD_W-1:0] value
);

  always_ff @(posedge clk) begin
    if (reset)
      value <= CARD_W'(CARD_MIN);
    else if (value >= CARD_W'(CARD_MAX))
      value <= CARD_W'(CARD_MIN);
    else
      value <= value + 1'b1;
  end

endmodule

// File: rtl/card_dealer.sv
// Six-slot card register file for one baccarat round.
// Deals one card per accepted request; feeds the per-card decoders.
module card_dealer
  import card_dealer_pkg::*;
#(
  parameter int CARD_MIN = 1,
  parameter int CARD_MAX = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 deal_valid,
  input  logic [SLOT_W-1:0]    deal_slot,
  input  logic                 test_mode,
  input  logic [CARD_W-1:0]    test_card,
  output logic                 deal_ready,
  output logic                 deal_done,
  output logic                 deal_err,
  output logic [NUM_SLOTS-1:0] dealt_mask,
  output logic [CARD_W-1:0]    player_card1,
  output logic [CARD_W-1:0]    player_card2,
  output logic [CARD_W-1:0]    player_card3,
  output logic [CARD_W-1:0]    dealer_card1,
  output logic [CARD_W-1:0]    dealer_card2,
  output logic [CARD_W-1:0]    dealer_card3
);

  state_t state;
  card_t  cards [NUM_SLOTS];
  slot_t  lat_slot;
  card_t  lat_val;
  card_t  cnt;
  logic [7:0] busy;

  card_counter #(
    .CARD_MIN(CARD_MIN),
    .CARD_MAX(CARD_MAX)
  ) u_counter (
    .clk  (clk),
    .reset(reset),
    .value(cnt)
  );

  // Slots 6 and 7 do not exist, so they always look occupied.
  assign busy = {2'b11, dealt_mask};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      deal_ready <= 1'b1;
      deal_done  <= 1'b0;
      deal_err   <= 1'b0;
      dealt_mask <= '0;
      lat_slot   <= '0;
      lat_val    <= EMPTY;
      for (int i = 0; i < NUM_SLOTS; i++)
        cards[i] <= EMPTY;
    end else if (clear) begin
      state      <= S_IDLE;
      deal_ready <= 1'b1;
      deal_done  <= 1'b0;
      deal_err   <= 1'b0;
      dealt_mask <= '0;
      for (int i = 0; i < NUM_SLOTS; i++)
        cards[i] <= EMPTY;
    end else begin
      deal_done <= 1'b0;
      deal_err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (deal_valid) begin
            lat_slot   <= deal_slot;
            lat_val    <= test_mode ? test_card : cnt;
            deal_ready <= 1'b0;
            deal_err   <= busy[deal_slot];
            state      <= busy[deal_slot] ? S_ERR : S_LOAD;
          end
        end
        S_LOAD: begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (lat_slot == SLOT_W'(i)) begin
              cards[i]      <= lat_val;
              dealt_mask[i] <= 1'b1;
            end
          end
          deal_done <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          deal_ready <= 1'b1;
          state      <= S_IDLE;
        end
        S_ERR: begin
          deal_ready <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          deal_ready <= 1'b1;
          state      <= S_IDLE;
        end
      endcase
    end
  end

  assign player_card1 = cards[SLOT_P1];
  assign player_card2 = cards[SLOT_P2];
  assign player_card3 = cards[SLOT_P3];
  assign dealer_card1 = cards[SLOT_D1];
  assign dealer_card2 = cards[SLOT_D2];
  assign dealer_card3 = cards[SLOT_D3];

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: reset, counter capture, deals,
// error cases, raw test values, clear and reset mid-deal.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       reset, clear, deal_valid, test_mode;
  logic [2:0] deal_slot;
  logic [3:0] test_card;
  logic       deal_ready, deal_done, deal_err;
  logic [5:0] dealt_mask;
  logic [3:0] player_card1, player_card2, player_card3;
  logic [3:0] dealer_card1, dealer_card2, dealer_card3;

  int checks = 0;
  int failures = 0;

  logic       o_rdy1, o_rdy2, o_done1, o_done2, o_done3;
  logic       o_err1, o_err2, o_err3;
  logic [5:0] o_mask1;

  card_dealer dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .deal_valid  (deal_valid),
    .deal_slot   (deal_slot),
    .test_mode   (test_mode),
    .test_card   (test_card),
    .deal_ready  (deal_ready),
    .deal_done   (deal_done),
    .deal_err    (deal_err),
    .dealt_mask  (dealt_mask),
    .player_card1(player_card1),
    .player_card2(player_card2),
    .player_card3(player_card3),
    .dealer_card1(dealer_card1),
    .dealer_card2(dealer_card2),
    .dealer_card3(dealer_card3)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] all_cards();
    return {player_card1, player_card2, player_card3,
            dealer_card1, dealer_card2, dealer_card3};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two reset edges; returns in the first post-reset cycle.
  task automatic do_reset();
    reset = 1'b1; clear = 1'b0; deal_valid = 1'b0;
    test_mode = 1'b0; test_card = 4'd0; deal_slot = 3'd0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Request in cycle N, observe N+1..N+3; returns in N+3 (IDLE).
  task automatic deal_req(input logic [2:0] slot, input logic tm,
                          input logic [3:0] tc, input logic hold);
    deal_slot = slot; test_mode = tm; test_card = tc;
    deal_valid = 1'b1;
    step();
    if (!hold) deal_valid = 1'b0;
    o_rdy1 = deal_ready; o_done1 = deal_done;
    o_err1 = deal_err; o_mask1 = dealt_mask;
    step();
    deal_valid = 1'b0;
    o_rdy2 = deal_ready; o_done2 = deal_done; o_err2 = deal_err;
    step();
    o_done3 = deal_done; o_err3 = deal_err;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (all_cards() !== 24'h0) begin
      failures++;
      $display("FAIL reset_cards got=%h exp=%h", all_cards(), 24'h0);
    end
    checks++;
    if (dealt_mask !== 6'b0) begin
      failures++;
      $display("FAIL reset_mask got=%b exp=%b", dealt_mask, 6'b0);
    end
    checks++;
    if ({deal_ready, deal_done, deal_err} !== 3'b100) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=%b",
               {deal_ready, deal_done, deal_err}, 3'b100);
    end
    step();
    step();
    checks++;
    if ({deal_ready, deal_done, deal_err} !== 3'b100) begin
      failures++;
      $display("FAIL idle_flags got=%b exp=%b",
               {deal_ready, deal_done, deal_err}, 3'b100);
    end
  endtask

  task automatic test_counter();
    do_reset();
    deal_req(3'd0, 1'b0, 4'd0, 1'b0);
    checks++;
    if (player_card1 !== 4'd1) begin
      failures++;
      $display("FAIL cnt_k0 got=%0d exp=%0d", player_card1, 1);
    end
    do_reset();
    repeat (12) step();
    deal_req(3'd0, 1'b0, 4'd0, 1'b0);
    checks++;
    if (player_card1 !== 4'd13) begin
      failures++;
      $display("FAIL cnt_k12 got=%0d exp=%0d", player_card1, 13);
    end
    deal_req(3'd1, 1'b0, 4'd0, 1'b0);
    checks++;
    if (player_card2 !== 4'd3) begin
      failures++;
      $display("FAIL cnt_k15 got=%0d exp=%0d", player_card2, 3);
    end
    do_reset();
    repeat (13) step();
    deal_req(3'd3, 1'b0, 4'd0, 1'b0);
    checks++;
    if (dealer_card1 !== 4'd1) begin
      failures++;
      $display("FAIL cnt_k13 got=%0d exp=%0d", dealer_card1, 1);
    end
  endtask

  task automatic test_directed();
    do_reset();
    deal_req(3'd2, 1'b1, 4'd7, 1'b0);
    checks++;
    if ({o_rdy1, o_rdy2} !== 2'b00) begin
      failures++;
      $display("FAIL dir_ready got=%b exp=%b", {o_rdy1, o_rdy2}, 2'b00);
    end
    checks++;
    if ({o_done1, o_done2, o_done3} !== 3'b010) begin
      failures++;
      $display("FAIL dir_done got=%b exp=%b",
               {o_done1, o_done2, o_done3}, 3'b010);
    end
    checks++;
    if (o_mask1 !== 6'b0) begin
      failures++;
      $display("FAIL dir_mask_n1 got=%b exp=%b", o_mask1, 6'b0);
    end
    checks++;
    if ({o_err1, o_err2, o_err3} !== 3'b000) begin
      failures++;
      $display("FAIL dir_err got=%b exp=%b",
               {o_err1, o_err2, o_err3}, 3'b000);
    end
    checks++;
    if (all_cards() !== 24'h007000 || dealt_mask !== 6'b000100) begin
      failures++;
      $display("FAIL dir_result got=%h/%b exp=%h/%b",
               all_cards(), dealt_mask, 24'h007000, 6'b000100);
    end
  endtask

  task automatic test_errors();
    deal_req(3'd2, 1'b1, 4'd9, 1'b0);
    checks++;
    if ({o_err1, o_err2, o_done1, o_done2, o_done3} !== 5'b10000) begin
      failures++;
      $display("FAIL occ_pulses got=%b exp=%b",
               {o_err1, o_err2, o_done1, o_done2, o_done3}, 5'b10000);
    end
    checks++;
    if (player_card3 !== 4'd7 || dealt_mask !== 6'b000100) begin
      failures++;
      $display("FAIL occ_keep got=%0d/%b exp=%0d/%b",
               player_card3, dealt_mask, 7, 6'b000100);
    end
    deal_req(3'd6, 1'b1, 4'd5, 1'b0);
    checks++;
    if ({o_err1, o_err2, o_done2} !== 3'b100 ||
        dealt_mask !== 6'b000100) begin
      failures++;
      $display("FAIL slot6 got=%b/%b exp=%b/%b",
               {o_err1, o_err2, o_done2}, dealt_mask, 3'b100, 6'b000100);
    end
    deal_req(3'd7, 1'b1, 4'd5, 1'b0);
    checks++;
    if ({o_err1, o_done2} !== 2'b10 || all_cards() !== 24'h007000) begin
      failures++;
      $display("FAIL slot7 got=%b/%h exp=%b/%h",
               {o_err1, o_done2}, all_cards(), 2'b10, 24'h007000);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] vals [6];
    vals = '{4'd1, 4'd10, 4'd11, 4'd12, 4'd13, 4'd4};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      deal_req(3'(i), 1'b1, vals[i], 1'b1);
      checks++;
      if ({o_done1, o_done2, o_done3, o_err1} !== 4'b0100) begin
        failures++;
        $display("FAIL fill_pulse%0d got=%b exp=%b", i,
                 {o_done1, o_done2, o_done3, o_err1}, 4'b0100);
      end
    end
    checks++;
    if (all_cards() !== 24'h1ABCD4 || dealt_mask !== 6'b111111) begin
      failures++;
      $display("FAIL fill_result got=%h/%b exp=%h/%b",
               all_cards(), dealt_mask, 24'h1ABCD4, 6'b111111);
    end
  endtask

  task automatic test_raw_values();
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (all_cards() !== 24'h0 || dealt_mask !== 6'b0 || deal_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_clear got=%h/%b/%b exp=%h/%b/%b",
               all_cards(), dealt_mask, deal_ready, 24'h0, 6'b0, 1'b1);
    end
    deal_req(3'd0, 1'b1, 4'd0, 1'b0);
    checks++;
    if (player_card1 !== 4'd0 || dealt_mask !== 6'b000001 || o_done2 !== 1'b1) begin
      failures++;
      $display("FAIL zero_card got=%0d/%b/%b exp=%0d/%b/%b",
               player_card1, dealt_mask, o_done2, 0, 6'b000001, 1'b1);
    end
    deal_req(3'd5, 1'b1, 4'd15, 1'b0);
    checks++;
    if (dealer_card3 !== 4'd15 || dealt_mask !== 6'b100001) begin
      failures++;
      $display("FAIL big_card got=%0d/%b exp=%0d/%b",
               dealer_card3, dealt_mask, 15, 6'b100001);
    end
  endtask

  task automatic test_clear_vs_valid();
    clear = 1'b1; deal_valid = 1'b1; deal_slot = 3'd3;
    test_mode = 1'b1; test_card = 4'd8;
    step();
    clear = 1'b0; deal_valid = 1'b0;
    checks++;
    if ({deal_ready, deal_err} !== 2'b10 || dealt_mask !== 6'b0) begin
      failures++;
      $display("FAIL clr_valid got=%b/%b exp=%b/%b",
               {deal_ready, deal_err}, dealt_mask, 2'b10, 6'b0);
    end
    step();
    checks++;
    if (deal_done !== 1'b0 || dealer_card1 !== 4'd0) begin
      failures++;
      $display("FAIL clr_valid2 got=%b/%0d exp=%b/%0d",
               deal_done, dealer_card1, 1'b0, 0);
    end
  endtask

  task automatic test_clear_mid();
    deal_req(3'd0, 1'b1, 4'd6, 1'b0);
    deal_slot = 3'd4; test_mode = 1'b1; test_card = 4'd9;
    deal_valid = 1'b1;
    step();
    deal_valid = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (all_cards() !== 24'h0 || dealt_mask !== 6'b0 ||
        deal_done !== 1'b0 || deal_ready !== 1'b1) begin
      failures++;
      $display("FAIL clr_mid got=%h/%b/%b/%b exp=%h/%b/%b/%b",
               all_cards(), dealt_mask, deal_done, deal_ready,
               24'h0, 6'b0, 1'b0, 1'b1);
    end
    step();
    checks++;
    if ({deal_done, deal_err} !== 2'b00 || dealer_card2 !== 4'd0) begin
      failures++;
      $display("FAIL clr_mid2 got=%b/%0d exp=%b/%0d",
               {deal_done, deal_err}, dealer_card2, 2'b00, 0);
    end
  endtask

  task automatic test_reset_mid();
    deal_req(3'd1, 1'b1, 4'd5, 1'b0);
    deal_slot = 3'd4; test_mode = 1'b1; test_card = 4'd9;
    deal_valid = 1'b1;
    step();
    deal_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (all_cards() !== 24'h0 || dealt_mask !== 6'b0 ||
        {deal_ready, deal_done, deal_err} !== 3'b100) begin
      failures++;
      $display("FAIL rst_mid got=%h/%b/%b exp=%h/%b/%b",
               all_cards(), dealt_mask, {deal_ready, deal_done, deal_err},
               24'h0, 6'b0, 3'b100);
    end
    deal_req(3'd4, 1'b0, 4'd0, 1'b0);
    checks++;
    if (dealer_card2 !== 4'd1 || o_done2 !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_cnt got=%0d/%b exp=%0d/%b",
               dealer_card2, o_done2, 1, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_counter();
    test_directed();
    test_errors();
    test_back_to_back();
    test_raw_values();
    test_clear_vs_valid();
    test_clear_mid();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
